// File: rtl/bcd_alu_serial.sv
// bcd_alu_serial
//   Multi-cycle binary/BCD add-subtract unit for the 65C816 datapath
//   (ADC/SBC at 8- or 16-bit width). Processes DPC nibbles per clock
//   through a registered carry, using a START/BUSY/DONE handshake.
//   The result and the flags are held until the next DONE.
//
// Parameters
//   DIGITS  operand width in nibbles (even, >= 4); W = 4*DIGITS
//   DPC     nibbles processed per clock (1 or 2)
//
// Ports
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   begin an operation (sampled only while BUSY=0)
//   A, B   in   operands (W bits)
//   CI     in   carry in (subtract: 1 = no borrow)
//   ADD    in   1 = A+B+CI, 0 = A-B-!CI
//   BCD    in   1 = decimal per-nibble correction
//   W16    in   0 = low two digits only, 1 = all DIGITS
//   BUSY   out  operation in progress
//   DONE   out  one-cycle pulse when S and the flags update
//   S      out  result (narrow op passes A[W-1:8] through)
//   CO     out  carry out of the top active nibble
//   VO     out  signed overflow from the uncorrected top nibble
//   ZO     out  active result bits all zero
//   NO     out  MSB of the active result
module bcd_alu_serial #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DPC    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  CI,
  input  logic                  ADD,
  input  logic                  BCD,
  input  logic                  W16,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   S,
  output logic                  CO,
  output logic                  VO,
  output logic                  ZO,
  output logic                  NO
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = $clog2(DIGITS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r, res_r;
  logic            c_r, add_r, bcd_r, w16_r;
  logic [IW-1:0]   idx;

  logic [IW-1:0]   n_act, idx_next;
  logic            last;
  logic [W-1:0]    res_next, res_fin;
  logic            carry_next;
  logic [3:0]      rtop;
  logic            atop, btop;
  logic            zero_fin, neg_fin;

  assign n_act    = w16_r ? IW'(DIGITS) : IW'(2);
  assign idx_next = idx + IW'(DPC);
  assign last     = (idx_next == n_act);

  // Digit slice for this clock; the last iteration leaves the operand and
  // raw-sum nibbles of the highest digit handled, which on the final clock
  // is the top active digit used for overflow.
  always_comb begin
    logic        c;
    logic [3:0]  an, bn, dig;
    logic [4:0]  t;
    int unsigned pos;

    c        = c_r;
    an       = '0;
    bn       = '0;
    dig      = '0;
    t        = '0;
    pos      = 0;
    res_next = res_r;
    rtop     = '0;
    atop     = 1'b0;
    btop     = 1'b0;

    for (int unsigned j = 0; j < DPC; j++) begin
      pos = 32'(idx) + j;
      an  = a_r[4*pos +: 4];
      bn  = add_r ? b_r[4*pos +: 4] : ~b_r[4*pos +: 4];
      t   = {1'b0, an} + {1'b0, bn} + {4'b0000, c};
      if (!bcd_r) begin
        dig = t[3:0];
        c   = t[4];
      end else if (add_r) begin
        if (t > 5'd9) begin
          dig = t[3:0] + 4'd6;
          c   = 1'b1;
        end else begin
          dig = t[3:0];
          c   = 1'b0;
        end
      end else begin
        if (!t[4]) begin
          dig = t[3:0] - 4'd6;
          c   = 1'b0;
        end else begin
          dig = t[3:0];
          c   = 1'b1;
        end
      end
      res_next[4*pos +: 4] = dig;
      rtop = t[3:0];
      atop = an[3];
      btop = bn[3];
    end
    carry_next = c;
  end

  // Narrow ops keep the upper byte of A (B-accumulator preservation).
  assign res_fin  = w16_r ? res_next : {a_r[W-1:8], res_next[7:0]};
  assign zero_fin = w16_r ? (res_next == '0) : (res_next[7:0] == 8'h00);
  assign neg_fin  = w16_r ? res_next[W-1] : res_next[7];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c_r   <= 1'b0;
      add_r <= 1'b0;
      bcd_r <= 1'b0;
      w16_r <= 1'b0;
      idx   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      S     <= '0;
      CO    <= 1'b0;
      VO    <= 1'b0;
      ZO    <= 1'b0;
      NO    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_r   <= A;
            b_r   <= B;
            c_r   <= CI;
            add_r <= ADD;
            bcd_r <= BCD;
            w16_r <= W16;
            res_r <= '0;
            idx   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_r <= res_next;
          c_r   <= carry_next;
          idx   <= idx_next;
          if (last) begin
            S     <= res_fin;
            CO    <= carry_next;
            VO    <= (atop == btop) && (rtop[3] != atop);
            ZO    <= zero_fin;
            NO    <= neg_fin;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
